kbd_cmd_decoder: RTL and testbench

Parametrised PS/2 command decoder between the `keyboard` scancode receiver and the Game-of-Life core, display and viewport logic. It consumes the validated scancode stream and handles the break prefix (F0) and the extended prefix (E0). It runs an explicit run-mode state machine, a multi-digit decimal pattern-ID entry, zoom/pan with hard clamping, and fixed-length command strobes.

---
 rtl/kbd_cmd_decoder.sv | 335 +++++++++++++++++++++++++++++++++
 tb/tb_kbd_cmd_decoder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_cmd_decoder.sv
// PS/2 command decoder: turns the validated scancode stream into run-mode control,
// pattern-ID entry, viewport zoom/pan, speed and fixed-length command strobes.
//
//   state      | meaning
//   -----------+----------------------------------------------
//   ST_IDLE    | stopped, digits/tab/shift edit the pattern ID
//   ST_RUNNING | evolution running, pattern entry locked out
//   ST_PAUSED  | evolution halted, can resume or enter MANUAL
//   ST_MANUAL  | movement keys steer the edit cursor
module kbd_cmd_decoder #(
   parameter int GRID_N       = 64,
   parameter int GRID_M       = 64,
   parameter int DIGITS       = 2,
   parameter int PULSE_CYCLES = 65536,
   parameter int MAX_ZOOM     = 5,
   parameter int MAX_SPEED    = 5
) (
   input  logic        clk_in,
   input  logic        reset_n,
   input  logic [7:0]  scancode,
   input  logic        scancode_valid,
   output logic        start,
   output logic        pause,
   output logic        clear,
   output logic        running,
   output logic        manual,
   output logic [3:0]  cursor_move,
   output logic [15:0] file_id,
   output logic        file_id_load,
   output logic [15:0] shift_x,
   output logic [15:0] shift_y,
   output logic [2:0]  scroll,
   output logic [3:0]  evo_left_shift,
   output logic [31:0] dpy_number
);

   localparam int BW = 4 * DIGITS;
   localparam int NW = $clog2(DIGITS + 1);
   localparam int CW = $clog2(PULSE_CYCLES + 1);
   localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
   localparam logic [16:0] GX = 17'(GRID_N);
   localparam logic [16:0] GY = 17'(GRID_M);

   typedef enum logic [1:0] {ST_IDLE, ST_RUNNING, ST_PAUSED, ST_MANUAL} state_t;

   state_t state_q, state_d;
   logic brk_q, brk_d, ext_q, ext_d;
   logic [BW-1:0] buf_q, buf_d, buf_inc, buf_dec;
   logic [NW-1:0] cnt_q, cnt_d;
   logic start_q, start_d, pause_q, pause_d, clear_q, clear_d;
   logic [CW-1:0] pcnt_q, pcnt_d;
   logic [3:0] cursor_move_q, cursor_move_d;
   logic [15:0] file_id_q, file_id_d;
   logic file_id_load_q, file_id_load_d;
   logic [15:0] shift_x_q, shift_x_d, shift_y_q, shift_y_d;
   logic [2:0] scroll_q, scroll_d;
   logic [3:0] evo_q, evo_d;
   logic dig_hit;
   logic [3:0] dig_val;
   logic [3:0] mv_dir;
   logic fire_start, fire_pause, fire_clear, commit;

   function automatic logic [16:0] lim_f(input logic [16:0] g, input logic [2:0] s);
      return g - (g >> s);
   endfunction

   function automatic logic [15:0] clamp_f(input logic [16:0] v, input logic [16:0] lim);
      return (v > lim) ? lim[15:0] : v[15:0];
   endfunction

   function automatic logic [15:0] pan_f(input logic [15:0] v, input logic dec,
                                         input logic inc, input logic [16:0] lim);
      logic [16:0] t;
      t = {1'b0, v};
      if (dec && t != 17'd0) t = t - 17'd1;
      if (inc) t = t + 17'd1;
      return clamp_f(t, lim);
   endfunction

   // Zooming keeps the view centred: the origin moves by a quarter/half of the window.
   function automatic logic [15:0] zin_f(input logic [15:0] v, input logic [16:0] g,
                                         input logic [2:0] s);
      logic [16:0] t;
      t = {1'b0, v} + (g >> ({1'b0, s} + 4'd2));
      return clamp_f(t, lim_f(g, s + 3'd1));
   endfunction

   function automatic logic [15:0] zout_f(input logic [15:0] v, input logic [16:0] g,
                                          input logic [2:0] s);
      logic [16:0] d;
      logic [16:0] t;
      d = g >> ({1'b0, s} + 4'd1);
      t = ({1'b0, v} > d) ? ({1'b0, v} - d) : 17'd0;
      return clamp_f(t, lim_f(g, s - 3'd1));
   endfunction

   function automatic logic [15:0] bcd2bin(input logic [BW-1:0] b);
      logic [15:0] acc;
      acc = '0;
      for (int i = DIGITS - 1; i >= 0; i--) acc = acc * 16'd10 + 16'(b[4*i +: 4]);
      return acc;
   endfunction

   always_comb begin
      dig_hit = 1'b1;
      dig_val = 4'd0;
      case (scancode)
         8'h45: dig_val = 4'd0;
         8'h16: dig_val = 4'd1;
         8'h1E: dig_val = 4'd2;
         8'h26: dig_val = 4'd3;
         8'h25: dig_val = 4'd4;
         8'h2E: dig_val = 4'd5;
         8'h36: dig_val = 4'd6;
         8'h3D: dig_val = 4'd7;
         8'h3E: dig_val = 4'd8;
         8'h46: dig_val = 4'd9;
         default: dig_hit = 1'b0;
      endcase
   end

   // mv_dir: bit0 left, bit1 up, bit2 down, bit3 right
   always_comb begin
      mv_dir = 4'b0000;
      if (ext_q) begin
         case (scancode)
            8'h6B: mv_dir = 4'b0001;
            8'h75: mv_dir = 4'b0010;
            8'h72: mv_dir = 4'b0100;
            8'h74: mv_dir = 4'b1000;
            default: mv_dir = 4'b0000;
         endcase
      end else begin
         case (scancode)
            8'h1C: mv_dir = 4'b0001;
            8'h1D: mv_dir = 4'b0010;
            8'h1B: mv_dir = 4'b0100;
            8'h23: mv_dir = 4'b1000;
            default: mv_dir = 4'b0000;
         endcase
      end
   end

   // Ripple BCD +1/-1; all-nines wraps to zero and zero wraps to all-nines.
   always_comb begin
      logic carry, borrow;
      buf_inc = buf_q;
      buf_dec = buf_q;
      carry   = 1'b1;
      borrow  = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (buf_q[4*i +: 4] == 4'd9) buf_inc[4*i +: 4] = 4'd0;
            else begin
               buf_inc[4*i +: 4] = buf_q[4*i +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
         if (borrow) begin
            if (buf_q[4*i +: 4] == 4'd0) buf_dec[4*i +: 4] = 4'd9;
            else begin
               buf_dec[4*i +: 4] = buf_q[4*i +: 4] - 4'd1;
               borrow = 1'b0;
            end
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      brk_d          = brk_q;
      ext_d          = ext_q;
      buf_d          = buf_q;
      cnt_d          = cnt_q;
      cursor_move_d  = 4'b0000;
      file_id_d      = file_id_q;
      file_id_load_d = 1'b0;
      shift_x_d      = shift_x_q;
      shift_y_d      = shift_y_q;
      scroll_d       = scroll_q;
      evo_d          = evo_q;
      start_d        = start_q;
      pause_d        = pause_q;
      clear_d        = clear_q;
      pcnt_d         = pcnt_q;
      fire_start     = 1'b0;
      fire_pause     = 1'b0;
      fire_clear     = 1'b0;
      commit         = 1'b0;

      if (scancode_valid) begin
         if (scancode == 8'hF0) brk_d = 1'b1;
         else if (scancode == 8'hE0) ext_d = 1'b1;
         else begin
            brk_d = 1'b0;
            ext_d = 1'b0;
            if (!brk_q) begin
               case (scancode)
                  8'h5A: if (state_q != ST_RUNNING) begin
                     state_d    = ST_RUNNING;
                     fire_start = 1'b1;
                  end
                  8'h4D: if (state_q == ST_RUNNING) begin
                     state_d    = ST_PAUSED;
                     fire_pause = 1'b1;
                  end
                  8'h2D: begin
                     state_d    = ST_IDLE;
                     fire_clear = 1'b1;
                     buf_d      = '0;
                     cnt_d      = '0;
                  end
                  8'h3A: if (state_q == ST_IDLE || state_q == ST_PAUSED) state_d = ST_MANUAL;
                  8'h31: if (state_q == ST_MANUAL) state_d = ST_IDLE;
                  8'h0D: if (state_q != ST_RUNNING) begin
                     buf_d  = buf_inc;
                     cnt_d  = '0;
                     commit = 1'b1;
                  end
                  8'h12: if (state_q != ST_RUNNING) begin
                     buf_d  = buf_dec;
                     cnt_d  = '0;
                     commit = 1'b1;
                  end
                  8'h55: if (scroll_q < 3'(MAX_ZOOM)) begin
                     scroll_d  = scroll_q + 3'd1;
                     shift_x_d = zin_f(shift_x_q, GX, scroll_q);
                     shift_y_d = zin_f(shift_y_q, GY, scroll_q);
                  end
                  8'h4E: if (scroll_q != 3'd0) begin
                     scroll_d  = scroll_q - 3'd1;
                     shift_x_d = zout_f(shift_x_q, GX, scroll_q);
                     shift_y_d = zout_f(shift_y_q, GY, scroll_q);
                  end
                  8'h41: if (evo_q < 4'(MAX_SPEED)) evo_d = evo_q + 4'd1;
                  8'h49: if (evo_q != 4'd0) evo_d = evo_q - 4'd1;
                  default: begin
                     if (dig_hit) begin
                        if (state_q != ST_RUNNING) begin
                           buf_d = BW'({((cnt_q == '0) ? {BW{1'b0}} : buf_q), dig_val});
                           if (cnt_q == NW'(DIGITS - 1)) begin
                              cnt_d  = '0;
                              commit = 1'b1;
                           end else cnt_d = cnt_q + NW'(1);
                        end
                     end else if (mv_dir != 4'b0000) begin
                        if (state_q == ST_MANUAL) cursor_move_d = mv_dir;
                        else begin
                           shift_x_d = pan_f(shift_x_q, mv_dir[0], mv_dir[3], lim_f(GX, scroll_q));
                           shift_y_d = pan_f(shift_y_q, mv_dir[1], mv_dir[2], lim_f(GY, scroll_q));
                        end
                     end
                  end
               endcase
            end
         end
      end

      if (commit) begin
         file_id_d      = bcd2bin(buf_d);
         file_id_load_d = 1'b1;
         shift_x_d      = '0;
         shift_y_d      = '0;
         scroll_d       = '0;
         evo_d          = 4'd2;
      end

      // A new command always wins over expiry of the current strobe.
      if (fire_start || fire_pause || fire_clear) begin
         start_d = fire_start;
         pause_d = fire_pause;
         clear_d = fire_clear;
         pcnt_d  = PULSE_LOAD;
      end else if (start_q || pause_q || clear_q) begin
         if (pcnt_q == '0) begin
            start_d = 1'b0;
            pause_d = 1'b0;
            clear_d = 1'b0;
         end else pcnt_d = pcnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         brk_q          <= 1'b0;
         ext_q          <= 1'b0;
         buf_q          <= '0;
         cnt_q          <= '0;
         start_q        <= 1'b0;
         pause_q        <= 1'b0;
         clear_q        <= 1'b0;
         pcnt_q         <= '0;
         cursor_move_q  <= 4'b0000;
         file_id_q      <= '0;
         file_id_load_q <= 1'b0;
         shift_x_q      <= '0;
         shift_y_q      <= '0;
         scroll_q       <= '0;
         evo_q          <= '0;
      end else begin
         state_q        <= state_d;
         brk_q          <= brk_d;
         ext_q          <= ext_d;
         buf_q          <= buf_d;
         cnt_q          <= cnt_d;
         start_q        <= start_d;
         pause_q        <= pause_d;
         clear_q        <= clear_d;
         pcnt_q         <= pcnt_d;
         cursor_move_q  <= cursor_move_d;
         file_id_q      <= file_id_d;
         file_id_load_q <= file_id_load_d;
         shift_x_q      <= shift_x_d;
         shift_y_q      <= shift_y_d;
         scroll_q       <= scroll_d;
         evo_q          <= evo_d;
      end
   end

   assign start          = start_q;
   assign pause          = pause_q;
   assign clear          = clear_q;
   assign running        = (state_q == ST_RUNNING);
   assign manual         = (state_q == ST_MANUAL);
   assign cursor_move    = cursor_move_q;
   assign file_id        = file_id_q;
   assign file_id_load   = file_id_load_q;
   assign shift_x        = shift_x_q;
   assign shift_y        = shift_y_q;
   assign scroll         = scroll_q;
   assign evo_left_shift = evo_q;
   assign dpy_number     = 32'(buf_q);

endmodule

// File: tb/tb_kbd_cmd_decoder.sv
// Scoreboard bench for kbd_cmd_decoder: an integer-level keyboard model predicts the
// outputs after every clock; a monitor pops and compares each prediction.
module tb_kbd_cmd_decoder;
   localparam int GN = 64, GM = 64, D = 2, P = 16, MZ = 5, MS = 5;
   localparam int MOD = (D == 1) ? 10 : (D == 2) ? 100 : (D == 3) ? 1000 : 10000;
   localparam int MI = 0, MR = 1, MP = 2, MM = 3;

   logic clk_in = 1'b0;
   logic reset_n = 1'b0;
   logic [7:0] scancode = 8'h00;
   logic scancode_valid = 1'b0;
   logic start, pause, clear, running, manual, file_id_load;
   logic [3:0] cursor_move, evo_left_shift;
   logic [15:0] file_id, shift_x, shift_y;
   logic [2:0] scroll;
   logic [31:0] dpy_number;

   kbd_cmd_decoder #(.GRID_N(GN), .GRID_M(GM), .DIGITS(D), .PULSE_CYCLES(P),
                     .MAX_ZOOM(MZ), .MAX_SPEED(MS)) dut (
      .clk_in(clk_in), .reset_n(reset_n), .scancode(scancode), .scancode_valid(scancode_valid),
      .start(start), .pause(pause), .clear(clear), .running(running), .manual(manual),
      .cursor_move(cursor_move), .file_id(file_id), .file_id_load(file_id_load),
      .shift_x(shift_x), .shift_y(shift_y), .scroll(scroll),
      .evo_left_shift(evo_left_shift), .dpy_number(dpy_number));

   always #5 clk_in = ~clk_in;

   typedef struct {
      bit st, pa, cl, run, man, ld;
      bit [3:0] cm;
      int fid, sx, sy, scr, evo;
      bit [31:0] dpy;
   } exp_t;
   exp_t q[$];
   int vectors = 0, miscompares = 0;

   int m_mode, m_buf, m_cnt, m_fid, m_sx, m_sy, m_scr, m_evo, m_skind, m_sleft;
   bit m_brk, m_ext, m_ld;
   bit [3:0] m_cm;

   function automatic int lim(input int g, input int s);
      return g - (g >> s);
   endfunction

   function automatic int clampi(input int v, input int hi);
      if (v < 0) return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   function automatic int digit_of(input bit [7:0] c);
      case (c)
         8'h45: return 0; 8'h16: return 1; 8'h1E: return 2; 8'h26: return 3;
         8'h25: return 4; 8'h2E: return 5; 8'h36: return 6; 8'h3D: return 7;
         8'h3E: return 8; 8'h46: return 9;
         default: return -1;
      endcase
   endfunction

   // 1 left, 2 up, 3 down, 4 right
   function automatic int dir_of(input bit [7:0] c, input bit e);
      if (e) case (c)
         8'h6B: return 1; 8'h75: return 2; 8'h72: return 3; 8'h74: return 4;
         default: return 0;
      endcase
      case (c)
         8'h1C: return 1; 8'h1D: return 2; 8'h1B: return 3; 8'h23: return 4;
         default: return 0;
      endcase
   endfunction

   function automatic void model_reset();
      m_mode = MI; m_buf = 0; m_cnt = 0; m_fid = 0; m_sx = 0; m_sy = 0; m_scr = 0;
      m_evo = 0; m_skind = 0; m_sleft = 0; m_brk = 0; m_ext = 0; m_ld = 0; m_cm = 0;
   endfunction

   function automatic void fire(input int k);
      m_skind = k;
      m_sleft = P;
   endfunction

   function automatic void do_commit();
      m_fid = m_buf; m_ld = 1; m_cnt = 0;
      m_sx = 0; m_sy = 0; m_scr = 0; m_evo = 2;
   endfunction

   function automatic void model_step(input bit v, input bit [7:0] c);
      bit b, e;
      int dg, dr;
      m_ld = 0;
      m_cm = 0;
      if (m_sleft > 0) m_sleft--;
      if (m_sleft == 0) m_skind = 0;
      if (!v) return;
      if (c == 8'hF0) begin m_brk = 1; return; end
      if (c == 8'hE0) begin m_ext = 1; return; end
      b = m_brk; e = m_ext;
      m_brk = 0; m_ext = 0;
      if (b) return;
      dg = digit_of(c);
      dr = dir_of(c, e);
      case (c)
         8'h5A: if (m_mode != MR) begin m_mode = MR; fire(1); end
         8'h4D: if (m_mode == MR) begin m_mode = MP; fire(2); end
         8'h2D: begin m_mode = MI; fire(3); m_buf = 0; m_cnt = 0; end
         8'h3A: if (m_mode == MI || m_mode == MP) m_mode = MM;
         8'h31: if (m_mode == MM) m_mode = MI;
         8'h0D: if (m_mode != MR) begin m_buf = (m_buf + 1) % MOD; do_commit(); end
         8'h12: if (m_mode != MR) begin m_buf = (m_buf + MOD - 1) % MOD; do_commit(); end
         8'h55: if (m_scr < MZ) begin
            m_sx = clampi(m_sx + (GN >> (m_scr + 2)), lim(GN, m_scr + 1));
            m_sy = clampi(m_sy + (GM >> (m_scr + 2)), lim(GM, m_scr + 1));
            m_scr++;
         end
         8'h4E: if (m_scr > 0) begin
            m_sx = clampi(m_sx - (GN >> (m_scr + 1)), lim(GN, m_scr - 1));
            m_sy = clampi(m_sy - (GM >> (m_scr + 1)), lim(GM, m_scr - 1));
            m_scr--;
         end
         8'h41: if (m_evo < MS) m_evo++;
         8'h49: if (m_evo > 0) m_evo--;
         default: begin
            if (dg >= 0) begin
               if (m_mode != MR) begin
                  if (m_cnt == 0) m_buf = 0;
                  m_buf = (m_buf * 10 + dg) % MOD;
                  m_cnt++;
                  if (m_cnt == D) do_commit();
               end
            end else if (dr != 0) begin
               if (m_mode == MM) m_cm = 4'(1 << (dr - 1));
               else case (dr)
                  1: m_sx = clampi(m_sx - 1, lim(GN, m_scr));
                  2: m_sy = clampi(m_sy - 1, lim(GM, m_scr));
                  3: m_sy = clampi(m_sy + 1, lim(GM, m_scr));
                  default: m_sx = clampi(m_sx + 1, lim(GN, m_scr));
               endcase
            end
         end
      endcase
   endfunction

   function automatic exp_t cur_exp();
      exp_t x;
      int v;
      x.st = (m_skind == 1); x.pa = (m_skind == 2); x.cl = (m_skind == 3);
      x.run = (m_mode == MR); x.man = (m_mode == MM);
      x.ld = m_ld; x.cm = m_cm; x.fid = m_fid; x.sx = m_sx; x.sy = m_sy;
      x.scr = m_scr; x.evo = m_evo;
      x.dpy = 0;
      v = m_buf;
      for (int i = 0; i < D; i++) begin
         x.dpy[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return x;
   endfunction

   task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] expv);
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, expv, $time);
      end
   endtask

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      cmp(n, act, expv);
   endtask

   task automatic reset_check();
      vectors++;
      cmp("rst_start", 32'(start), 0);         cmp("rst_pause", 32'(pause), 0);
      cmp("rst_clear", 32'(clear), 0);         cmp("rst_running", 32'(running), 0);
      cmp("rst_manual", 32'(manual), 0);       cmp("rst_cursor", 32'(cursor_move), 0);
      cmp("rst_file_id", 32'(file_id), 0);     cmp("rst_load", 32'(file_id_load), 0);
      cmp("rst_shift_x", 32'(shift_x), 0);     cmp("rst_shift_y", 32'(shift_y), 0);
      cmp("rst_scroll", 32'(scroll), 0);       cmp("rst_evo", 32'(evo_left_shift), 0);
      cmp("rst_dpy", dpy_number, 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk_in);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            cmp("start", 32'(start), 32'(e.st));        cmp("pause", 32'(pause), 32'(e.pa));
            cmp("clear", 32'(clear), 32'(e.cl));        cmp("running", 32'(running), 32'(e.run));
            cmp("manual", 32'(manual), 32'(e.man));     cmp("cursor_move", 32'(cursor_move), 32'(e.cm));
            cmp("file_id", 32'(file_id), e.fid);        cmp("file_id_load", 32'(file_id_load), 32'(e.ld));
            cmp("shift_x", 32'(shift_x), e.sx);         cmp("shift_y", 32'(shift_y), e.sy);
            cmp("scroll", 32'(scroll), e.scr);          cmp("evo", 32'(evo_left_shift), e.evo);
            cmp("dpy_number", dpy_number, e.dpy);
         end
      end
   end

   task automatic send(input bit [7:0] c);
      @(posedge clk_in);
      #2;
      scancode = c;
      scancode_valid = 1'b1;
      model_step(1'b1, c);
      q.push_back(cur_exp());
   endtask

   task automatic idle();
      @(posedge clk_in);
      #2;
      scancode_valid = 1'b0;
      scancode = 8'($urandom);
      model_step(1'b0, 8'h00);
      q.push_back(cur_exp());
   endtask

   task automatic release_reset();
      @(posedge clk_in);
      #2;
      reset_n = 1'b1;
      scancode_valid = 1'b0;
      model_step(1'b0, 8'h00);
      q.push_back(cur_exp());
   endtask

   task automatic reset_now();
      @(posedge clk_in);
      #2;
      scancode_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      reset_check();
      model_reset();
      repeat (2) @(posedge clk_in);
      release_reset();
   endtask

   logic [7:0] codes [27] = '{8'h5A, 8'h4D, 8'h2D, 8'h3A, 8'h31, 8'h45, 8'h16, 8'h1E, 8'h26,
                              8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h0D, 8'h12, 8'h1C,
                              8'h1D, 8'h1B, 8'h23, 8'h55, 8'h4E, 8'h41, 8'h49, 8'h11, 8'h22};
   logic [7:0] arrows [4] = '{8'h6B, 8'h75, 8'h72, 8'h74};

   initial begin : stim
      int r;
      model_reset();
      #3;
      reset_check();
      release_reset();

      send(8'h5A); idle();
      chk("enter_start", 32'(start), 1); chk("enter_running", 32'(running), 1);
      repeat (4) idle();
      send(8'h4D); idle();
      chk("p_start_drop", 32'(start), 0); chk("p_pause", 32'(pause), 1);
      repeat (P + 2) idle();

      send(8'h2D);
      send(8'h1E); send(8'h26); idle();
      chk("id_23", 32'(file_id), 23); chk("id_load", 32'(file_id_load), 1);
      send(8'h0D); idle(); chk("tab_24", 32'(file_id), 24);
      send(8'h46); send(8'h46); send(8'h0D); idle(); chk("tab_wrap_0", 32'(file_id), 0);
      send(8'h12); idle(); chk("shift_wrap_99", 32'(file_id), 99);

      send(8'hF0); send(8'h16); idle(); chk("break_ignored", dpy_number, 32'h99);
      send(8'hE0); send(8'h74); idle(); chk("pan_lim0", 32'(shift_x), 0);

      send(8'h55); idle();
      chk("zoom_scroll", 32'(scroll), 1); chk("zoom_shift", 32'(shift_x), 16);
      repeat (20) send(8'h23);
      idle(); chk("pan_sat", 32'(shift_x), 32);
      send(8'h4E); idle();
      chk("unzoom_scroll", 32'(scroll), 0); chk("unzoom_shift", 32'(shift_x), 0);

      send(8'h3A); send(8'h1C); idle(); chk("cursor_left", 32'(cursor_move), 1);
      send(8'hE0); send(8'h75); idle(); chk("cursor_up", 32'(cursor_move), 2);
      send(8'h31); idle(); chk("manual_exit", 32'(manual), 0);

      send(8'h5A); send(8'h16); send(8'h16); idle();
      chk("run_digits_ignored", dpy_number, 32'h99);
      reset_now();

      send(8'h5A);
      repeat (P - 1) idle();
      send(8'h4D);
      repeat (P + 2) idle();

      for (int i = 0; i < 1500; i++) begin
         r = $urandom_range(0, 99);
         if (r < 3) repeat (P) idle();
         else if (r < 12) idle();
         else if (r < 22) begin send(8'hF0); send(codes[$urandom_range(0, 26)]); end
         else if (r < 38) begin send(8'hE0); send(arrows[$urandom_range(0, 3)]); end
         else if (r < 40) begin send(8'hE0); send(8'hF0); send(arrows[$urandom_range(0, 3)]); end
         else send(codes[$urandom_range(0, 26)]);
      end
      idle();
      @(posedge clk_in);
      #3;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
